// File: rtl/srff_pkg.sv
// Shared SR flip-flop definitions: command encoding and excitation helper.
// Also usable by the matching SR down counter.
package srff_pkg;

  // Command bit 1 is S, bit 0 is R.
  typedef enum logic [1:0] {
    SR_HOLD    = 2'b00,
    SR_RESET   = 2'b01,
    SR_SET     = 2'b10,
    SR_ILLEGAL = 2'b11
  } sr_cmd_e;

  // Returns the SR command that moves a cell from cur to nxt.
  // It never produces SR_ILLEGAL.
  function automatic sr_cmd_e sr_excite(input logic cur, input logic nxt);
    sr_cmd_e cmd;
    if (cur == nxt) begin
      cmd = SR_HOLD;
    end else if (nxt) begin
      cmd = SR_SET;
    end else begin
      cmd = SR_RESET;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/sync_up_srff_counter_if.sv
// Control and observation bundle for the SR-flip-flop up counter.
interface sync_up_srff_counter_if #(
  parameter int unsigned WIDTH = 2
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_ovf;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;
  logic [WIDTH-1:0] s_vec;
  logic [WIDTH-1:0] r_vec;

  modport master (
    output en, load, load_val, clr_ovf,
    input  q, tc, ovf, s_vec, r_vec
  );

  modport slave (
    input  en, load, load_val, clr_ovf,
    output q, tc, ovf, s_vec, r_vec
  );
endinterface

// File: rtl/srff_cell.sv
// Single-bit SR flip-flop with a synchronous active-high clear.
// When S and R are both asserted, S takes precedence.
module srff_cell (
  input  logic clk,
  input  logic reset,
  input  logic i_s,
  input  logic i_r,
  output logic o_q
);
  logic r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= 1'b0;
    end else if (i_s) begin
      r_q <= 1'b1;
    end else if (i_r) begin
      r_q <= 1'b0;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/sync_up_srff_counter.sv
// Modulo-MODULUS up counter whose state bits are held in SR cells.
// Adds enable, parallel load, terminal count and a sticky overflow flag.
module sync_up_srff_counter
  import srff_pkg::*;
#(
  parameter int unsigned WIDTH   = 2,
  parameter int unsigned MODULUS = 4
) (
  input logic                  clk,
  input logic                  reset,
  sync_up_srff_counter_if.slave bus
);
  if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_bad_param
    $fatal(1, "sync_up_srff_counter: MODULUS out of range for WIDTH");
  end

  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_nxt;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_r;
  logic             w_set_ovf;
  logic             r_ovf;

  // Reset is folded into the next state so that s_vec/r_vec show the clearing
  // transition. The cells also clear on their own reset input.
  always_comb begin
    w_nxt     = w_q;
    w_set_ovf = 1'b0;
    if (reset) begin
      w_nxt = '0;
    end else if (bus.load) begin
      if ({1'b0, bus.load_val} < MOD_EXT) begin
        w_nxt = bus.load_val;
      end else begin
        w_nxt     = '0;
        w_set_ovf = 1'b1;
      end
    end else if (bus.en) begin
      if (w_q == LAST) begin
        w_nxt     = '0;
        w_set_ovf = 1'b1;
      end else begin
        w_nxt = w_q + 1'b1;
      end
    end
  end

  always_comb begin
    w_s = '0;
    w_r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      {w_s[i], w_r[i]} = sr_excite(w_q[i], w_nxt[i]);
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    srff_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .i_s   (w_s[g]),
      .i_r   (w_r[g]),
      .o_q   (w_q[g])
    );
  end

  // A set event takes precedence over a clear requested in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_set_ovf) begin
      r_ovf <= 1'b1;
    end else if (bus.clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign bus.q     = w_q;
  assign bus.tc    = (w_q == LAST) && bus.en && !bus.load;
  assign bus.ovf   = r_ovf;
  assign bus.s_vec = w_s;
  assign bus.r_vec = w_r;
endmodule

// File: tb/tb_sync_up_srff_counter.sv
// Bench for two counter configurations: 2-bit mod-4 and 3-bit mod-5.
// Both counters receive the same stimulus and are compared against an arithmetic model.
module tb_sync_up_srff_counter;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sync_up_srff_counter_if #(.WIDTH(2)) ifa ();
  sync_up_srff_counter_if #(.WIDTH(3)) ifb ();

  sync_up_srff_counter #(.WIDTH(2), .MODULUS(4)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  sync_up_srff_counter #(.WIDTH(3), .MODULUS(5)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int mod_k[2] = '{4, 5};
  int msk[2]   = '{3, 7};
  string nm[2] = '{"a", "b"};
  int mq[2]    = '{0, 0};
  int movf[2]  = '{0, 0};
  bit valid    = 1'b0;
  int pre_tc[2], pre_s[2], pre_r[2];
  int exp_a[5] = '{1, 2, 3, 0, 1};
  int exp_b[5] = '{1, 2, 3, 4, 0};

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
  endtask

  function automatic int ref_nxt(input bit rst, input bit en, input bit ld,
                                 input int lv, input int q, input int m);
    if (rst) return 0;
    if (ld) return (lv < m) ? lv : 0;
    if (en) return (q + 1) % m;
    return q;
  endfunction

  function automatic bit ref_set(input bit en, input bit ld, input int lv,
                                 input int q, input int m);
    if (ld) return lv >= m;
    return en && (q == m - 1);
  endfunction

  task automatic step(input bit rst, input bit en, input bit ld, input int lv, input bit clr);
    int lvk[2], nx[2], gq[2], gov[2], gtc[2], gs[2], gr[2];
    reset        = rst;
    ifa.en       = en;
    ifb.en       = en;
    ifa.load     = ld;
    ifb.load     = ld;
    ifa.load_val = 2'(lv);
    ifb.load_val = 3'(lv);
    ifa.clr_ovf  = clr;
    ifb.clr_ovf  = clr;
    #1;
    gtc[0] = ifa.tc;  gs[0] = ifa.s_vec;  gr[0] = ifa.r_vec;
    gtc[1] = ifb.tc;  gs[1] = ifb.s_vec;  gr[1] = ifb.r_vec;
    for (int k = 0; k < 2; k++) begin
      lvk[k]    = lv & msk[k];
      nx[k]     = ref_nxt(rst, en, ld, lvk[k], mq[k], mod_k[k]);
      pre_tc[k] = gtc[k];
      pre_s[k]  = gs[k];
      pre_r[k]  = gr[k];
      if (valid) begin
        check({nm[k], ".tc"}, gtc[k], int'(mq[k] == mod_k[k] - 1 && en && !ld));
        check({nm[k], ".s_vec"}, gs[k], nx[k] & ~mq[k] & msk[k]);
        check({nm[k], ".r_vec"}, gr[k], ~nx[k] & mq[k] & msk[k]);
        check({nm[k], ".s_and_r"}, gs[k] & gr[k], 0);
        check({nm[k], ".s_or_r"}, gs[k] | gr[k], mq[k] ^ nx[k]);
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) movf[k] = 0;
      else if (ref_set(en, ld, lvk[k], mq[k], mod_k[k])) movf[k] = 1;
      else if (clr) movf[k] = 0;
      mq[k] = nx[k];
    end
    if (rst) valid = 1'b1;
    #1;
    gq[0] = ifa.q;  gov[0] = ifa.ovf;
    gq[1] = ifb.q;  gov[1] = ifb.ovf;
    if (valid) begin
      for (int k = 0; k < 2; k++) begin
        check({nm[k], ".q"}, gq[k], mq[k]);
        check({nm[k], ".ovf"}, gov[k], movf[k]);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    ifa.en = 1'b0; ifa.load = 1'b0; ifa.load_val = '0; ifa.clr_ovf = 1'b0;
    ifb.en = 1'b0; ifb.load = 1'b0; ifb.load_val = '0; ifb.clr_ovf = 1'b0;
    @(negedge clk);

    step(1, 0, 0, 0, 0);
    check("rst.a.q", int'(ifa.q), 0);
    check("rst.a.ovf", int'(ifa.ovf), 0);
    check("rst.b.q", int'(ifb.q), 0);
    check("rst.b.ovf", int'(ifb.ovf), 0);

    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0);
      check("cnt.a.q", int'(ifa.q), exp_a[i]);
      check("cnt.b.q", int'(ifb.q), exp_b[i]);
      if (i == 2) begin
        check("cnt.a.tc_low", pre_tc[0], 0);
        check("cnt.a.ovf_low", int'(ifa.ovf), 0);
      end
      if (i == 3) check("wrap.a.tc", pre_tc[0], 1);
      if (i == 4) begin
        check("wrap.b.s_vec", pre_s[1], 0);
        check("wrap.b.r_vec", pre_r[1], 4);
        check("wrap.a.tc_after", pre_tc[0], 0);
      end
    end
    check("wrap.a.ovf", int'(ifa.ovf), 1);
    check("wrap.b.ovf", int'(ifb.ovf), 1);

    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 2, 0);
    check("ld_en.a.tc", pre_tc[0], 0);
    check("ld_en.a.q", int'(ifa.q), 2);
    check("ld_en.b.q", int'(ifb.q), 2);
    step(0, 1, 0, 0, 0);
    check("ld_then_en.a.q", int'(ifa.q), 3);

    step(0, 0, 1, 6, 0);
    check("badld.b.q", int'(ifb.q), 0);
    check("badld.b.ovf", int'(ifb.ovf), 1);
    step(0, 0, 0, 0, 1);
    check("clr.b.ovf", int'(ifb.ovf), 0);
    step(0, 0, 1, 4, 0);
    check("ld4.b.q", int'(ifb.q), 4);
    check("ld4.b.ovf", int'(ifb.ovf), 0);
    step(0, 1, 0, 0, 1);
    check("wrapclr.b.q", int'(ifb.q), 0);
    check("wrapclr.b.ovf", int'(ifb.ovf), 1);

    step(0, 0, 1, 3, 0);
    check("ld3.a.q", int'(ifa.q), 3);
    step(1, 1, 0, 0, 0);
    check("midrst.a.q", int'(ifa.q), 0);
    check("midrst.a.ovf", int'(ifa.ovf), 0);
    step(0, 1, 0, 0, 0);
    check("postrst.a.q", int'(ifa.q), 1);

    repeat (10000) begin
      step($urandom_range(63) == 0, $urandom_range(3) != 0,
           $urandom_range(7) == 0, int'($urandom_range(7)),
           $urandom_range(7) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sync_up_srff_counter.md
# sync_up_srff_counter

Parameterised synchronous modulo-N up counter built from SR flip-flop cells, the counting-up counterpart of our SR-flip-flop down counter. Each state bit is held in an SR cell whose S/R inputs come from next-state excitation logic. The block adds enable, parallel load, terminal-count and a sticky wrap flag so it can serve as a cycle/event counter in control paths. The S/R excitation vectors are exported so verification can check that SR cells never see the illegal S=R=1 condition.

## Interface
- WIDTH, 2, number of counter bits (1..16)
- MODULUS, 4, count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- en  in  1  count enable; advances q by one when high
- load  in  1  parallel load strobe; priority over en
- load_val  in  WIDTH  value loaded when load=1
- clr_ovf  in  1  clears sticky ovf
- q  out  WIDTH  current count (registered)
- tc  out  1  terminal count: q==MODULUS-1 and en=1 and load=0 (combinational)
- ovf  out  1  sticky: set on wrap or on out-of-range load
- s_vec  out  WIDTH  per-bit SR set excitation for the current cycle
- r_vec  out  WIDTH  per-bit SR reset excitation for the current cycle

## Operation
- Reset (sync, highest priority): q=0, ovf=0. s_vec/r_vec are combinational and reflect the all-zero next state.
- Next-state selection, in priority order:
  - load=1, load_val < MODULUS: nxt=load_val.
  - load=1, load_val >= MODULUS: nxt=0, ovf set.
  - en=1, q==MODULUS-1: nxt=0 (wrap), ovf set.
  - en=1, otherwise: nxt=q+1.
  - else: nxt=q (hold).
- SR excitation per bit i:
  - s_vec[i] = nxt[i] & ~q[i]
  - r_vec[i] = ~nxt[i] & q[i]
  - When a bit does not change, both are 0 (hold). S and R are never both 1.
- SR cell update: q[i] <= s ? 1 : r ? 0 : q[i].
- ovf handling:
  - clr_ovf clears ovf.
  - If a set event and clr_ovf occur in the same cycle, set wins (ovf=1).
- All arithmetic is WIDTH bits unsigned. The increment never exceeds MODULUS-1 because the wrap check precedes it.

## Timing
- q changes one clock after the qualifying en/load sample; there is no additional latency.
- tc, s_vec and r_vec are combinational from q, en, load and load_val in the same cycle.
- ovf rises in the cycle after the wrap or bad-load edge.
- Reset asserted mid-count forces q=0 on that edge regardless of en/load. The first count after deassert yields q=1 if en=1.
- load and en high together: load wins, no increment, tc=0.
- With MODULUS=2**WIDTH, wrap is the natural rollover and still sets ovf.

## Structure
- Shared package srff_pkg holds:
  - the SR command encoding (SR_HOLD=2'b00, SR_RESET=2'b01, SR_SET=2'b10, SR_ILLEGAL=2'b11)
  - a function sr_excite(cur,nxt) returning the 2-bit command, reusable by the existing down counter.
- One sub-module, srff_cell: a single-bit SR flip-flop with sync active-high reset to 0. It is instantiated WIDTH times via generate.
- Top level contains next-state mux, excitation, tc/ovf logic.
- Elaboration check: MODULUS within range, otherwise fatal.

## Test plan
- Reset then en=1 for 5 cycles, WIDTH=2, MODULUS=4 -> q: 1,2,3,0,1. tc=1 only while q=3; ovf=1 from the cycle after the 3->0 wrap.
- WIDTH=3, MODULUS=5, en=1 continuous -> q sequence 0,1,2,3,4,0. The 4->0 step shows s_vec=000, r_vec=100.
- load=1, load_val=2, en=1 in the same cycle -> q=2 next cycle (no increment), tc=0. Then en=1 -> q=3.
- MODULUS=5, load_val=6 -> q=0, ovf=1. Assert clr_ovf alone -> ovf=0. Assert clr_ovf during a wrap -> ovf stays 1.
- reset pulsed while q=3 with en=1 -> q=0 on that edge. Next cycle q=1.
- Random en/load/load_val for 10k cycles against a reference model -> q matches every cycle, (s_vec & r_vec)==0 always, and (s_vec|r_vec) equals q^nxt.
